// File: rtl/conv_bn_pkg.sv
// Shared types and width helpers for the multi-channel conv + folded batch-norm block.
package conv_bn_pkg;

  typedef enum logic [2:0] {IDLE, ACC, BIAS, SCALE, OUT} state_t;

  // Accumulator sized so NUM_ELE*MAX_CH full-scale products plus bias cannot overflow.
  function automatic int acc_width(int wa, int wb, int ne, int mc);
    return wa + wb + $clog2(ne * mc) + 1;
  endfunction

  function automatic int cnt_width(int ne, int mc);
    return $clog2(ne * mc + 1);
  endfunction

  function automatic longint sat_max(int wy);
    return (64'sd1 <<< (wy - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(int wy);
    return -(64'sd1 <<< (wy - 1));
  endfunction

endpackage

// File: rtl/conv_bn_mc_mac.sv
// conv_mac_unit: signed multiply-accumulate with synchronous clear, beat enable and bias add.
module conv_mac_unit #(
  parameter int WIDTH_A    = 18,
  parameter int WIDTH_B    = 18,
  parameter int WIDTH_BIAS = 18,
  parameter int ACC_W      = 45
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    add_bias,
  input  logic signed [WIDTH_A-1:0]    a,
  input  logic signed [WIDTH_B-1:0]    b,
  input  logic signed [WIDTH_BIAS-1:0] bias,
  output logic signed [ACC_W-1:0]      acc
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a) * PW'(b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end else if (add_bias) begin
      acc <= acc + ACC_W'(bias);
    end
  end

endmodule

// File: rtl/conv_bn_mc.sv
// conv_bn_mc: multi-channel conv MAC sequencer with folded batch-norm and output saturation.
// Build option: define CONV_BN_RELU_EN to clamp negative results to zero in the SCALE stage.
module conv_bn_mc
  import conv_bn_pkg::*;
#(
  parameter int NUM_ELE  = 9,
  parameter int MAX_CH   = 16,
  parameter int WIDTH_A  = 18,
  parameter int WIDTH_B  = 18,
  parameter int WIDTH_eW = 18,
  parameter int WIDTH_eB = 18,
  parameter int SHIFT    = 12,
  parameter int WIDTH_Y  = 18
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_CH+1)-1:0]    ch_cnt,
  input  logic signed [WIDTH_eW-1:0]     e_w,
  input  logic signed [WIDTH_eB-1:0]     e_b,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH_A-1:0]      Ain,
  input  logic signed [WIDTH_B-1:0]      Bin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [WIDTH_Y-1:0]      y,
  output logic                           ready,
  output logic                           finish
);

  localparam int CH_W  = $clog2(MAX_CH + 1);
  localparam int CNT_W = cnt_width(NUM_ELE, MAX_CH);
  localparam int ACC_W = acc_width(WIDTH_A, WIDTH_B, NUM_ELE, MAX_CH);
  localparam int P_W   = ACC_W + WIDTH_eW;
  localparam logic signed [P_W-1:0] Y_MAX = P_W'(sat_max(WIDTH_Y));
  localparam logic signed [P_W-1:0] Y_MIN = P_W'(sat_min(WIDTH_Y));

  state_t                     state_reg;
  logic signed [WIDTH_eW-1:0] e_w_reg;
  logic signed [WIDTH_eB-1:0] e_b_reg;
  logic [CNT_W-1:0]           beat_cnt_reg;
  logic [CNT_W-1:0]           beat_total_reg;
  logic [CH_W-1:0]            ch_eff;
  logic                       beat_last;
  logic                       mac_clr, mac_en, mac_bias;
  logic signed [ACC_W-1:0]    acc;
  logic signed [P_W-1:0]      scaled, shifted;
  logic signed [WIDTH_Y-1:0]  y_next;

  always_comb begin
    ch_eff = ch_cnt;
    if (ch_cnt == '0)
      ch_eff = CH_W'(1);
    else if (ch_cnt > CH_W'(MAX_CH))
      ch_eff = CH_W'(MAX_CH);
  end

  assign beat_last = (beat_cnt_reg == beat_total_reg - CNT_W'(1));
  assign mac_clr   = (state_reg == IDLE) && start;
  assign mac_en    = (state_reg == ACC) && in_valid;
  assign mac_bias  = (state_reg == BIAS);

  conv_mac_unit #(
    .WIDTH_A   (WIDTH_A),
    .WIDTH_B   (WIDTH_B),
    .WIDTH_BIAS(WIDTH_eB),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .add_bias(mac_bias),
    .a       (Ain),
    .b       (Bin),
    .bias    (e_b_reg),
    .acc     (acc)
  );

  // Full-width scale then floor shift; saturation compares before narrowing.
  assign scaled  = P_W'(acc) * P_W'(e_w_reg);
  assign shifted = scaled >>> SHIFT;

  always_comb begin
    y_next = shifted[WIDTH_Y-1:0];
    if (shifted > Y_MAX)
      y_next = Y_MAX[WIDTH_Y-1:0];
    else if (shifted < Y_MIN)
      y_next = Y_MIN[WIDTH_Y-1:0];
`ifdef CONV_BN_RELU_EN
    if (y_next[WIDTH_Y-1])
      y_next = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      e_w_reg        <= '0;
      e_b_reg        <= '0;
      beat_cnt_reg   <= '0;
      beat_total_reg <= '0;
      y              <= '0;
      out_valid      <= 1'b0;
      in_ready       <= 1'b0;
      finish         <= 1'b0;
      ready          <= 1'b1;
    end else begin
      finish <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            e_w_reg        <= e_w;
            e_b_reg        <= e_b;
            beat_cnt_reg   <= '0;
            beat_total_reg <= CNT_W'(NUM_ELE) * CNT_W'(ch_eff);
            ready          <= 1'b0;
            in_ready       <= 1'b1;
            state_reg      <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (beat_last) begin
              in_ready  <= 1'b0;
              state_reg <= BIAS;
            end
          end
        end
        BIAS: state_reg <= SCALE;
        SCALE: begin
          y         <= y_next;
          out_valid <= 1'b1;
          state_reg <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            finish    <= 1'b1;
            ready     <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bn_mc.sv
// Self-checking bench for conv_bn_mc: directed and randomized transactions against a sum-of-products model.
module tb_conv_bn_mc;

  localparam int NUM_ELE = 9;
  localparam int MAX_CH  = 16;
  localparam int SHIFT   = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [4:0] ch_cnt = '0;
  logic signed [17:0] e_w = '0;
  logic signed [17:0] e_b = '0;
  logic signed [17:0] Ain = '0;
  logic signed [17:0] Bin = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, ready, finish;
  logic signed [17:0] y;

  int pass_cnt = 0;
  int total_cnt = 0;
  int a_q[$];
  int b_q[$];

  always #5 clk = ~clk;

  conv_bn_mc #(
    .NUM_ELE(NUM_ELE), .MAX_CH(MAX_CH), .WIDTH_A(18), .WIDTH_B(18),
    .WIDTH_eW(18), .WIDTH_eB(18), .SHIFT(SHIFT), .WIDTH_Y(18)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ch_cnt(ch_cnt),
    .e_w(e_w), .e_b(e_b), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ready(ready), .finish(finish)
  );

  // Reference: plain dot product of the queued operands, then bias, scale, floor shift, clamp.
  function automatic longint ref_y(longint ew, longint eb);
    longint s;
    longint r;
    s = 0;
    foreach (a_q[i]) s += longint'(a_q[i]) * longint'(b_q[i]);
    r = ((s + eb) * ew) >>> SHIFT;
    if (r > 131071) r = 131071;
    else if (r < -131072) r = -131072;
`ifdef CONV_BN_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic int rand18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic fill_const(input int n, input int a, input int b);
    a_q.delete(); b_q.delete();
    for (int i = 0; i < n; i++) begin a_q.push_back(a); b_q.push_back(b); end
  endtask

  task automatic fill_rand(input int n, input int lo, input int hi);
    a_q.delete(); b_q.delete();
    for (int i = 0; i < n; i++) begin
      a_q.push_back(int'($urandom_range(0, hi - lo)) + lo);
      b_q.push_back(int'($urandom_range(0, hi - lo)) + lo);
    end
  endtask

  // Drives one output computation; after start the e_w/e_b pins are scrambled to prove latching.
  task automatic drive_txn(input logic [4:0] ch, input logic signed [17:0] ew, input logic signed [17:0] eb,
                           input bit gaps, input bit poke, input int hold,
                           output logic signed [17:0] y_obs, output int edges, output bit tmo,
                           output int fin_cnt, output bit busy_ok, output bit hold_ok);
    int idx;
    int cyc;
    bit took;
    tmo = 0; busy_ok = 1; hold_ok = 1; fin_cnt = 0; edges = 0;
    start = 1'b1; ch_cnt = ch; e_w = ew; e_b = eb;
    @(posedge clk); #1;
    start = 1'b0; e_w = ~ew; e_b = ~eb;
    idx = 0; cyc = 0;
    while (idx < a_q.size() && cyc < 2000) begin
      in_valid = !(gaps && cyc[0]);
      Ain = 18'(a_q[idx]);
      Bin = 18'(b_q[idx]);
      start = poke && (cyc == 3);
      if (ready !== 1'b0) busy_ok = 0;
      took = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (took) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < a_q.size()) tmo = 1;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    if (out_valid !== 1'b1) tmo = 1;
    y_obs = y;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || y !== y_obs || finish !== 1'b0) hold_ok = 0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (finish === 1'b1) fin_cnt++;
    if (out_valid !== 1'b0 || ready !== 1'b1) hold_ok = 0;
    @(posedge clk); #1;
    if (finish === 1'b1) fin_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, in_ready, finish} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {out_valid, in_ready, finish});
    else pass_cnt++;
    total_cnt++;
    if (y !== 18'sd0) $display("FAIL reset_y got %0d want 0", y); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else pass_cnt++;
    $display("txn reset: ready=%b out_valid=%b y=%0d", ready, out_valid, y);
  endtask

  task automatic test_basic();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_const(9, 2, 3);
    ex = ref_y(4096, 6);
    drive_txn(5'd1, 18'sd4096, 18'sd6, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn basic: y=%0d expected=%0d edges=%0d", yo, ex, ed);
    total_cnt++;
    if (longint'(yo) !== ex) $display("FAIL basic_y got %0d want %0d", yo, ex); else pass_cnt++;
    // The accepting edge counts as the first; out_valid is seen after the third.
    total_cnt++;
    if (ed !== 3) $display("FAIL basic_latency got %0d want 3", ed); else pass_cnt++;
    total_cnt++;
    if (fc !== 1) $display("FAIL basic_finish got %0d want 1", fc); else pass_cnt++;
    total_cnt++;
    if ({to, bo, ho} !== 3'b011) $display("FAIL basic_protocol got %b want 011", {to, bo, ho}); else pass_cnt++;
  endtask

  task automatic test_negative();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_const(27, 1, -1);
    ex = ref_y(4096, 0);
    drive_txn(5'd3, 18'sd4096, 18'sd0, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn negative: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex) $display("FAIL negative_y got %0d want %0d", yo, ex); else pass_cnt++;
    total_cnt++;
    if ({to, fc} !== {1'b0, 32'd1}) $display("FAIL negative_done got to=%b fin=%0d want 0/1", to, fc); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_const(144, 131071, 131071);
    ex = ref_y(131071, 0);
    drive_txn(5'd16, 18'sd131071, 18'sd0, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn sat_pos: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex || to) $display("FAIL sat_pos_y got %0d want %0d", yo, ex); else pass_cnt++;
    fill_const(144, 131071, -131071);
    ex = ref_y(131071, 0);
    drive_txn(5'd16, 18'sd131071, 18'sd0, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn sat_neg: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex || to) $display("FAIL sat_neg_y got %0d want %0d", yo, ex); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_const(9, 2, 3);
    ex = ref_y(4096, 6);
    drive_txn(5'd1, 18'sd4096, 18'sd6, 1, 0, 5, yo, ed, to, fc, bo, ho);
    $display("txn stall: y=%0d expected=%0d finish_pulses=%0d", yo, ex, fc);
    total_cnt++;
    if (longint'(yo) !== ex) $display("FAIL stall_y got %0d want %0d", yo, ex); else pass_cnt++;
    total_cnt++;
    if (ho !== 1'b1) $display("FAIL stall_hold got %b want 1", ho); else pass_cnt++;
    total_cnt++;
    if (fc !== 1) $display("FAIL stall_finish got %0d want 1", fc); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_rand(18, -500, 500);
    ex = ref_y(3000, -200);
    drive_txn(5'd2, 18'sd3000, -18'sd200, 0, 1, 0, yo, ed, to, fc, bo, ho);
    $display("txn start_ignored: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex || to) $display("FAIL start_ignored_y got %0d want %0d", yo, ex); else pass_cnt++;
  endtask

  task automatic test_ch_bounds();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    fill_rand(9, -1000, 1000);
    ex = ref_y(5000, 77);
    drive_txn(5'd0, 18'sd5000, 18'sd77, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn ch_zero: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex || to) $display("FAIL ch_zero_y got %0d want %0d to=%b", yo, ex, to); else pass_cnt++;
    fill_rand(144, -300, 300);
    ex = ref_y(2500, -31);
    drive_txn(5'd20, 18'sd2500, -18'sd31, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn ch_clamp: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex || to) $display("FAIL ch_clamp_y got %0d want %0d to=%b", yo, ex, to); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    start = 1'b1; ch_cnt = 5'd1; e_w = 18'sd4096; e_b = 18'sd1000;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Ain = 18'sd20000; Bin = 18'sd30000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, finish} !== 3'b000)
      $display("FAIL reset_mid_flags got %b want 000", {out_valid, in_ready, finish});
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({ready, finish} !== 2'b10) $display("FAIL reset_mid_ready got %b want 10", {ready, finish}); else pass_cnt++;
    fill_const(9, 2, 3);
    ex = ref_y(4096, 6);
    drive_txn(5'd1, 18'sd4096, 18'sd6, 0, 0, 0, yo, ed, to, fc, bo, ho);
    $display("txn after_reset: y=%0d expected=%0d", yo, ex);
    total_cnt++;
    if (longint'(yo) !== ex) $display("FAIL reset_mid_next_y got %0d want %0d", yo, ex); else pass_cnt++;
  endtask

  task automatic test_random();
    logic signed [17:0] yo; int ed, fc; bit to, bo, ho; longint ex;
    logic signed [17:0] ew, eb;
    int ch;
    for (int t = 0; t < 6; t++) begin
      ch = int'($urandom_range(1, 4));
      a_q.delete(); b_q.delete();
      for (int i = 0; i < NUM_ELE * ch; i++) begin
        a_q.push_back(rand18());
        b_q.push_back(rand18() >>> $urandom_range(0, 12));
      end
      ew = 18'(rand18() >>> $urandom_range(0, 14));
      eb = 18'(rand18());
      ex = ref_y(longint'(ew), longint'(eb));
      drive_txn(5'(ch), ew, eb, bit'($urandom_range(0, 1)), 0, int'($urandom_range(0, 3)),
                yo, ed, to, fc, bo, ho);
      $display("txn random%0d: ch=%0d y=%0d expected=%0d edges=%0d", t, ch, yo, ex, ed);
      total_cnt++;
      if (longint'(yo) !== ex) $display("FAIL random%0d_y got %0d want %0d", t, yo, ex); else pass_cnt++;
      total_cnt++;
      if ({to, bo, ho} !== 3'b011 || fc !== 1)
        $display("FAIL random%0d_protocol got %b fin=%0d want 011 fin=1", t, {to, bo, ho}, fc);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_stall();
    test_start_ignored();
    test_ch_bounds();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
